// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive sweep checker.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  // Clock edges from the edge that samples start up to the edge that raises done.
  function automatic int unsigned cycles_per_sweep(input int unsigned w,
                                                   input int unsigned settle);
    return ((32'd1 << w) * (settle + 32'd1)) + 32'd1;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle timer: reloaded when a vector is first driven. expired is high in the
// SETTLE-th cycle after the load, so the vector is held for exactly SETTLE cycles.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] Reload = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;

  // Down-counter: load takes priority, then count down to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= Reload;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive sweep checker: walks dut_in through 0 .. 2**W-1, compares the DUT
// response against the reference model and reports pass, first failure and a
// mismatch count. Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep on
// the first mismatch, leaving dut_in at the failing vector.
module exhaustive_sweep_checker
  import sweep_pkg::*;
#(
  parameter int unsigned W      = 2,
  parameter int unsigned OW     = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [W-1:0]  dut_in,
  input  logic [OW-1:0] dut_out,
  input  logic [OW-1:0] ref_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  fail_in,
  output logic [OW-1:0] fail_got,
  output logic [OW-1:0] fail_exp,
  output logic [W:0]    err_cnt
);

  localparam logic [W:0] ErrMax = {1'b1, {W{1'b0}}};

  sweep_state_t  state_q, state_d;
  logic [W-1:0]  vec_q, vec_d;
  logic [W:0]    err_q, err_d;
  logic [W-1:0]  fail_in_q, fail_in_d;
  logic [OW-1:0] fail_got_q, fail_got_d;
  logic [OW-1:0] fail_exp_q, fail_exp_d;

  logic mismatch;
  logic last_vec;
  logic timer_load;
  logic timer_expired;

  // Case inequality so an X/Z response from the DUT counts as a mismatch.
  assign mismatch = (dut_out !== ref_out);
  // All-ones detected explicitly so the vector counter never wraps.
  assign last_vec = (vec_q == {W{1'b1}});

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (state_q == DRIVE),
    .expired (timer_expired)
  );

  // Next-state logic for the FSM, vector counter and capture registers.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    err_d      = err_q;
    fail_in_d  = fail_in_q;
    fail_got_d = fail_got_q;
    fail_exp_d = fail_exp_q;
    timer_load = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = DRIVE;
          vec_d      = '0;
          err_d      = '0;
          fail_in_d  = '0;
          fail_got_d = '0;
          fail_exp_d = '0;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        if (timer_expired) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != ErrMax) begin
            err_d = err_q + 1'b1;
          end
          // Only the first mismatch of a sweep is captured.
          if (err_q == '0) begin
            fail_in_d  = vec_q;
            fail_got_d = dut_out;
            fail_exp_d = ref_out;
          end
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_d = DONE;
        end else begin
          state_d    = DRIVE;
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
        end
`else
        if (last_vec) begin
          state_d = DONE;
        end else begin
          state_d    = DRIVE;
          vec_d      = vec_q + 1'b1;
          timer_load = 1'b1;
        end
`endif
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      err_q      <= '0;
      fail_in_q  <= '0;
      fail_got_q <= '0;
      fail_exp_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      fail_in_q  <= fail_in_d;
      fail_got_q <= fail_got_d;
      fail_exp_q <= fail_exp_d;
    end
  end

  assign dut_in   = vec_q;
  assign busy     = (state_q == DRIVE) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign pass     = (state_q == DONE) && (err_q == '0);
  assign fail_in  = fail_in_q;
  assign fail_got = fail_got_q;
  assign fail_exp = fail_exp_q;
  assign err_cnt  = err_q;

endmodule
